pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 109 ++++++++++
 tb/tb_pipe_stage_reg.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register with flush, freeze (hold or bubble), operand forwarding and stall counting
module pipe_stage_reg #(
    parameter int DW        = 16,
    parameter int NOPS      = 2,
    parameter int NFWD      = 3,
    parameter int CTRLW     = 3,
    parameter int HOLD_MODE = 1,
    parameter int CW        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 freeze,
    input  logic                 br_taken,
    input  logic                 valid_in,
    input  logic [DW-1:0]        pc_in,
    input  logic [DW-1:0]        pc2_in,
    input  logic [DW-1:0]        IR_in,
    input  logic [CTRLW-1:0]     alu_ctrl_in,
    input  logic                 reg_wr_en_in,
    input  logic                 mem_wr_en_in,
    input  logic [NOPS*DW-1:0]   opnd_in,
    input  logic [NFWD*DW-1:0]   fwd_data,
    input  logic [NOPS*NFWD-1:0] fwd_en,
    output logic                 valid_out,
    output logic [DW-1:0]        pc_out,
    output logic [DW-1:0]        pc2_out,
    output logic [DW-1:0]        IR_out,
    output logic [CTRLW-1:0]     alu_ctrl_out,
    output logic                 reg_wr_en_out,
    output logic                 mem_wr_en_out,
    output logic [NOPS*DW-1:0]   opnd_out,
    output logic [CW-1:0]        stall_cnt,
    output logic                 stall_sat
);

    logic [NOPS*DW-1:0] opnd_sel;
    logic [NOPS*DW-1:0] opnd_frz;
    logic [NOPS-1:0]    fwd_any;

    // Per-channel forwarding mux: scanning from the top down lets the lowest source index win
    always_comb begin
        opnd_sel = opnd_in;
        opnd_frz = opnd_out;
        fwd_any  = '0;
        for (int j = 0; j < NOPS; j++) begin
            for (int k = NFWD - 1; k >= 0; k--) begin
                if (fwd_en[j*NFWD+k]) begin
                    opnd_sel[j*DW +: DW] = fwd_data[k*DW +: DW];
                    fwd_any[j] = 1'b1;
                end
            end
            if (fwd_any[j]) opnd_frz[j*DW +: DW] = opnd_sel[j*DW +: DW];
        end
    end

    // Stage register: reset beats flush, flush beats freeze, freeze beats advance
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out     <= 1'b0;
            pc_out        <= '0;
            pc2_out       <= '0;
            IR_out        <= '0;
            alu_ctrl_out  <= '0;
            reg_wr_en_out <= 1'b0;
            mem_wr_en_out <= 1'b0;
            opnd_out      <= '0;
        end else if (br_taken) begin
            valid_out     <= 1'b0;
            pc_out        <= pc_in;
            pc2_out       <= pc2_in;
            IR_out        <= IR_in;
            alu_ctrl_out  <= alu_ctrl_in;
            reg_wr_en_out <= 1'b0;
            mem_wr_en_out <= 1'b0;
            opnd_out      <= opnd_sel;
        end else if (freeze) begin
            if (HOLD_MODE == 0) begin
                valid_out     <= 1'b0;
                pc_out        <= '0;
                pc2_out       <= '0;
                IR_out        <= '0;
                alu_ctrl_out  <= '0;
                reg_wr_en_out <= 1'b0;
                mem_wr_en_out <= 1'b0;
                opnd_out      <= '0;
            end else begin
                opnd_out <= opnd_frz;
            end
        end else begin
            valid_out     <= valid_in;
            pc_out        <= pc_in;
            pc2_out       <= pc2_in;
            IR_out        <= IR_in;
            alu_ctrl_out  <= alu_ctrl_in;
            reg_wr_en_out <= reg_wr_en_in & valid_in;
            mem_wr_en_out <= mem_wr_en_in & valid_in;
            opnd_out      <= opnd_sel;
        end
    end

    // Stall counter: counts frozen cycles of a live instruction, saturating, cleared on any non-freeze
    always_ff @(posedge clk) begin
        if (rst || br_taken || !freeze) stall_cnt <= '0;
        else if (valid_out && !stall_sat) stall_cnt <= stall_cnt + CW'(1);
    end

    assign stall_sat = &stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg in hold, bubble and narrow-counter configurations
module tb_pipe_stage_reg;

    typedef struct packed {
        logic        rst, frz, br, vin;
        logic [15:0] pc, pc2, ir;
        logic [2:0]  ctrl;
        logic        rw, mw;
        logic [31:0] op;
        logic [47:0] fd;
        logic [5:0]  fe;
    } in_t;

    typedef struct packed {
        logic        v;
        logic [15:0] pc, pc2, ir;
        logic [2:0]  ctrl;
        logic        rw, mw;
        logic [31:0] op;
        logic [7:0]  cnt;
        logic        sat;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1, freeze = 1'b0, br_taken = 1'b0, valid_in = 1'b0;
    logic reg_wr_en_in = 1'b0, mem_wr_en_in = 1'b0;
    logic [15:0] pc_in = '0, pc2_in = '0, ir_in = '0;
    logic [2:0]  alu_ctrl_in = '0;
    logic [31:0] opnd_in = '0;
    logic [47:0] fwd_data = '0;
    logic [5:0]  fwd_en = '0;

    logic        v_a, v_b, v_c, rw_a, rw_b, rw_c, mw_a, mw_b, mw_c, sat_a, sat_b, sat_c;
    logic [15:0] pc_a, pc_b, pc_c, pc2_a, pc2_b, pc2_c, ir_a, ir_b, ir_c;
    logic [2:0]  ct_a, ct_b, ct_c;
    logic [31:0] op_a, op_b, op_c;
    logic [7:0]  cnt_a, cnt_b;
    logic [2:0]  cnt_c;
    out_t act_a, act_b, act_c;
    out_t ma = '0, mb = '0, mc = '0;
    out_t qa[$], qb[$], qc[$];
    int tests = 0, fails = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign act_a = {v_a, pc_a, pc2_a, ir_a, ct_a, rw_a, mw_a, op_a, cnt_a, sat_a};
    assign act_b = {v_b, pc_b, pc2_b, ir_b, ct_b, rw_b, mw_b, op_b, cnt_b, sat_b};
    assign act_c = {v_c, pc_c, pc2_c, ir_c, ct_c, rw_c, mw_c, op_c, 5'b0, cnt_c, sat_c};

    pipe_stage_reg u_a (
        .clk(clk), .rst(rst), .freeze(freeze), .br_taken(br_taken), .valid_in(valid_in),
        .pc_in(pc_in), .pc2_in(pc2_in), .IR_in(ir_in), .alu_ctrl_in(alu_ctrl_in),
        .reg_wr_en_in(reg_wr_en_in), .mem_wr_en_in(mem_wr_en_in), .opnd_in(opnd_in),
        .fwd_data(fwd_data), .fwd_en(fwd_en), .valid_out(v_a), .pc_out(pc_a), .pc2_out(pc2_a),
        .IR_out(ir_a), .alu_ctrl_out(ct_a), .reg_wr_en_out(rw_a), .mem_wr_en_out(mw_a),
        .opnd_out(op_a), .stall_cnt(cnt_a), .stall_sat(sat_a));

    pipe_stage_reg #(.HOLD_MODE(0)) u_b (
        .clk(clk), .rst(rst), .freeze(freeze), .br_taken(br_taken), .valid_in(valid_in),
        .pc_in(pc_in), .pc2_in(pc2_in), .IR_in(ir_in), .alu_ctrl_in(alu_ctrl_in),
        .reg_wr_en_in(reg_wr_en_in), .mem_wr_en_in(mem_wr_en_in), .opnd_in(opnd_in),
        .fwd_data(fwd_data), .fwd_en(fwd_en), .valid_out(v_b), .pc_out(pc_b), .pc2_out(pc2_b),
        .IR_out(ir_b), .alu_ctrl_out(ct_b), .reg_wr_en_out(rw_b), .mem_wr_en_out(mw_b),
        .opnd_out(op_b), .stall_cnt(cnt_b), .stall_sat(sat_b));

    pipe_stage_reg #(.CW(3)) u_c (
        .clk(clk), .rst(rst), .freeze(freeze), .br_taken(br_taken), .valid_in(valid_in),
        .pc_in(pc_in), .pc2_in(pc2_in), .IR_in(ir_in), .alu_ctrl_in(alu_ctrl_in),
        .reg_wr_en_in(reg_wr_en_in), .mem_wr_en_in(mem_wr_en_in), .opnd_in(opnd_in),
        .fwd_data(fwd_data), .fwd_en(fwd_en), .valid_out(v_c), .pc_out(pc_c), .pc2_out(pc2_c),
        .IR_out(ir_c), .alu_ctrl_out(ct_c), .reg_wr_en_out(rw_c), .mem_wr_en_out(mw_c),
        .opnd_out(op_c), .stall_cnt(cnt_c), .stall_sat(sat_c));

    // Reference: what the stage shows after one edge, given what it showed before and the inputs
    function automatic out_t model(out_t s, in_t i, bit hold, int maxc);
        out_t n;
        logic [15:0] f[2];
        bit any[2];
        int c;
        for (int j = 0; j < 2; j++) begin
            any[j] = 0;
            f[j] = i.op[j*16 +: 16];
            for (int k = 0; k < 3; k++)
                if (!any[j] && i.fe[j*3+k]) begin
                    any[j] = 1;
                    f[j] = i.fd[k*16 +: 16];
                end
        end
        n = s;
        if (i.rst) n = '0;
        else if (!i.frz || i.br) begin
            n.pc = i.pc;
            n.pc2 = i.pc2;
            n.ir = i.ir;
            n.ctrl = i.ctrl;
            n.op = {f[1], f[0]};
            n.v = i.vin && !i.br;
            n.rw = i.rw && n.v;
            n.mw = i.mw && n.v;
            n.cnt = 0;
        end else begin
            c = int'(s.cnt);
            if (s.v && c < maxc) c = c + 1;
            if (!hold) n = '0;
            else for (int j = 0; j < 2; j++) if (any[j]) n.op[j*16 +: 16] = f[j];
            n.cnt = 8'(c);
        end
        n.sat = (int'(n.cnt) == maxc);
        return n;
    endfunction

    function automatic in_t mk(bit r, bit f, bit b, bit v);
        in_t t;
        t.rst = r; t.frz = f; t.br = b; t.vin = v;
        t.pc = 16'($urandom); t.pc2 = 16'($urandom); t.ir = 16'($urandom);
        t.ctrl = 3'($urandom); t.rw = 1'($urandom); t.mw = 1'($urandom);
        t.op = $urandom;
        t.fd = {16'($urandom), $urandom};
        t.fe = ($urandom_range(0, 1) == 1) ? 6'($urandom) : 6'b0;
        return t;
    endfunction

    task automatic step(in_t t);
        @(negedge clk);
        rst = t.rst; freeze = t.frz; br_taken = t.br; valid_in = t.vin;
        pc_in = t.pc; pc2_in = t.pc2; ir_in = t.ir; alu_ctrl_in = t.ctrl;
        reg_wr_en_in = t.rw; mem_wr_en_in = t.mw;
        opnd_in = t.op; fwd_data = t.fd; fwd_en = t.fe;
        ma = model(ma, t, 1, 255); qa.push_back(ma);
        mb = model(mb, t, 0, 255); qb.push_back(mb);
        mc = model(mc, t, 1, 7);   qc.push_back(mc);
    endtask

    task automatic cmp(string nm, out_t a, out_t e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, a, e);
        end
    endtask

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic settle;
        @(posedge clk);
        #2;
    endtask

    // Monitor: every edge after stimulus, each DUT must match the oldest expected snapshot
    initial forever begin
        @(posedge clk);
        #1;
        if (qa.size() > 0) cmp("dut_hold", act_a, qa.pop_front());
        if (qb.size() > 0) cmp("dut_bubble", act_b, qb.pop_front());
        if (qc.size() > 0) cmp("dut_cw3", act_c, qc.pop_front());
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        in_t t;
        t = mk(1, 0, 0, 0); step(t); step(t);
        settle;
        chk("reset_valid", 32'(v_a), 32'd0);
        chk("reset_opnd", op_a, 32'd0);
        t = mk(0, 0, 0, 1);
        t.op = {16'h2222, 16'h1111};
        t.fd = {16'hCCCC, 16'hBBBB, 16'hAAAA};
        t.fe = 6'b000110;
        step(t);
        settle;
        chk("fwd_ch0", 32'(op_a[15:0]), 32'h0000BBBB);
        chk("fwd_ch1", 32'(op_a[31:16]), 32'h00002222);
        t = mk(0, 0, 0, 1); t.ir = 16'h1234; t.fe = '0;
        step(t);
        for (int c = 1; c <= 3; c++) begin
            t = mk(0, 1, 0, 1);
            t.fe = (c == 2) ? 6'b001000 : 6'b0;
            if (c == 2) t.fd[15:0] = 16'h5A5A;
            step(t);
            settle;
            chk("hold_ir", 32'(ir_a), 32'h00001234);
            if (c >= 2) chk("late_fwd_ch1", 32'(op_a[31:16]), 32'h00005A5A);
            if (c == 1) begin
                chk("bubble_valid", 32'(v_b), 32'd0);
                chk("bubble_payload", 32'(ir_b) | 32'(pc_b) | op_b, 32'd0);
            end
        end
        chk("hold_stall_cnt", 32'(cnt_a), 32'd3);
        t = mk(0, 1, 1, 1); t.rw = 1; t.mw = 1;
        step(t);
        settle;
        chk("flush_flags", {29'd0, v_a, rw_a, mw_a}, 32'd0);
        chk("flush_cnt", 32'(cnt_a), 32'd0);
        step(mk(0, 0, 0, 1));
        repeat (10) step(mk(0, 1, 0, 1));
        settle;
        chk("sat_cnt", 32'(cnt_c), 32'd7);
        chk("sat_flag", 32'(sat_c), 32'd1);
        step(mk(0, 0, 0, 1));
        settle;
        chk("unsat_cnt", 32'(cnt_c), 32'd0);
        chk("unsat_flag", 32'(sat_c), 32'd0);
        step(mk(0, 0, 0, 1));
        repeat (2) step(mk(0, 1, 0, 1));
        step(mk(1, 1, 0, 1));
        settle;
        chk("rst_mid_stall", {v_a, 15'd0, pc_a} | op_a | 32'(cnt_a), 32'd0);
        t = mk(0, 0, 0, 1); t.pc = 16'hBEEF;
        step(t);
        settle;
        chk("post_rst_pc", 32'(pc_a), 32'h0000BEEF);
        chk("post_rst_valid", 32'(v_a), 32'd1);
        for (int n = 0; n < 400; n++)
            step(mk($urandom_range(0, 31) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0));
        repeat (3) settle;
        chk("queues_drained", 32'(qa.size() + qb.size() + qc.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
